controller_shared_ram: RTL
==========================

// Module: controller_shared_ram
// PURPOSE
//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on one clock,
//  shared between the Nios II data master and the motion/sensor logic of the controller.
//  Adds to the plain dual-port RAM: selectable pipelined read latency with readdatavalid,
//  a hardware clear engine after reset, and defined per-byte write-collision arbitration.
// PARAMETERS
//  DATA_WIDTH      32  word width in bits; must be a multiple of 8
//  ADDR_WIDTH      11  word address width; DEPTH = 2**ADDR_WIDTH
//  READ_LATENCY    1   cycles from read acceptance to readdatavalid; legal values 1 or 2
//  CLEAR_ON_RESET  1   1: fill every word with CLEAR_VALUE after reset; 0: no clear
//  CLEAR_VALUE     0   DATA_WIDTH-bit fill pattern
// PORTS
//  clk               in   1             single clock for both slaves
//  reset             in   1             asynchronous, active-high reset
//  sN_address        in   ADDR_WIDTH    word address, N = 1,2
//  sN_byteenable     in   DATA_WIDTH/8  byte lanes for writes
//  sN_chipselect     in   1             slave select
//  sN_read           in   1             read request
//  sN_write          in   1             write request
//  sN_writedata      in   DATA_WIDTH    write data
//  sN_waitrequest    out  1             1 = command not accepted this cycle
//  sN_readdata       out  DATA_WIDTH    read data, qualified by readdatavalid
//  sN_readdatavalid  out  1             one-cycle pulse per accepted read
//  busy              out  1             1 while clear engine is running
//  collision_count   out  16            saturating count of overlapping same-address writes
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; clear counter 0; all readdata 0,
//    readdatavalid 0, collision_count 0; busy 0; waitrequest 1 (both ports).
//  - FSM: IDLE -> CLEAR (CLEAR_ON_RESET=1) or READY (=0) on the first clk after reset release.
//    CLEAR writes CLEAR_VALUE to address 0,1,..,DEPTH-1, one word per clk, busy=1, waitrequest=1;
//    after address DEPTH-1 is written -> READY next clk. READY: waitrequest=0, busy=0, permanent.
//  - Reset mid-CLEAR aborts; the clear restarts from address 0 after release. No state retained.
//  - Accept: cmd accepted when chipselect & (read|write) & ~waitrequest. chipselect=0 ignores all.
//  - read & write together on one port: write is performed, read dropped, no readdatavalid.
//  - Read: readdata/readdatavalid appear exactly READ_LATENCY clks after acceptance; one read per
//    clk per port sustained; readdatavalid otherwise 0; readdata holds its last value.
//  - Write: only enabled byte lanes updated; byteenable=0 is a legal no-op. Visible to any
//    read accepted on the following clk or later (either port).
//  - Same clk, same address, read on one port + write on the other: read returns OLD data.
//  - Same clk, same address, both write: lanes enabled on s1 take s1 data; lanes enabled only
//    on s2 take s2 data. If (s1_byteenable & s2_byteenable) != 0, collision_count += 1,
//    saturating at 16'hFFFF. Different addresses never collide.
//  - Pipelined reads in flight when reset asserts are discarded (readdatavalid forced 0).
// TESTING
//  1 Reset, CLEAR_ON_RESET=1, CLEAR_VALUE=32'hA5A5A5A5 -> busy/waitrequest high for exactly 2048
//    clks; then reading any of 0, 1023, 2047 returns 32'hA5A5A5A5.
//  2 READY: s1 write addr 5 data 32'h11223344 be 4'b1111; next clk s2 read addr 5 -> readdata
//    32'h11223344, readdatavalid exactly READ_LATENCY (1, rerun with 2) clks later.
//  3 Same clk addr 9: s1 write 32'hAAAAAAAA be 4'b0011, s2 write 32'hBBBBBBBB be 4'b0110 ->
//    word 32'h00BBAAAA (from cleared 0), collision_count 1; repeat with disjoint be -> count stays 1.
//  4 Word 3 = 32'h0; same clk s1 write addr 3 32'hFFFFFFFF, s2 read addr 3 -> s2 readdata 32'h0;
//    s2 read addr 3 next clk -> 32'hFFFFFFFF.
//  5 Back-to-back s1 reads addrs 0..7 each clk -> 8 consecutive readdatavalid pulses, data in order.
//  6 Assert reset at clear address 1000 -> after release clear restarts at 0, busy for 2048 clks;
//    force 65536 overlapping collisions -> collision_count holds 16'hFFFF.

Source files
------------

// File: rtl/controller_shared_ram.sv
// Dual-port on-chip RAM shared by two Avalon-MM slaves on one clock.
// Adds a post-reset clear engine, selectable read latency and byte-lane write arbitration.
module controller_shared_ram #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic                    s2_waitrequest,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    busy,
    output logic [15:0]             collision_count
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_addr;
    logic                    ready;
    logic                    collide;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Index 0 is s1, index 1 is s2.
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][BYTES-1:0]      be;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic [1:0]                 rd_acc;
    logic [1:0]                 wr_acc;
    logic [1:0]                 p1_valid;
    logic [1:0]                 p2_valid;
    logic [1:0][DATA_WIDTH-1:0] p1_data;
    logic [1:0][DATA_WIDTH-1:0] p2_data;
    logic [1:0][DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rvalid;

    assign addr  = {s2_address, s1_address};
    assign be    = {s2_byteenable, s1_byteenable};
    assign wdata = {s2_writedata, s1_writedata};

    assign ready          = (state == READY);
    assign busy           = (state == CLEAR);
    assign s1_waitrequest = ~ready;
    assign s2_waitrequest = ~ready;

    // A read issued together with a write on the same port is dropped.
    assign wr_acc[0] = ready & s1_chipselect & s1_write;
    assign wr_acc[1] = ready & s2_chipselect & s2_write;
    assign rd_acc[0] = ready & s1_chipselect & s1_read & ~s1_write;
    assign rd_acc[1] = ready & s2_chipselect & s2_read & ~s2_write;

    assign collide = wr_acc[0] & wr_acc[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clear_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clear_addr <= clear_addr + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            CLEAR:   if (clear_addr == '1) state_next = READY;
            READY:   state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    // s2 lanes are written first so s1 wins any lane both ports enable.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[clear_addr] <= CLEAR_VALUE;
        for (int p = 1; p >= 0; p--) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_acc[p] && be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid <= '0;
            p2_valid <= '0;
            p1_data  <= '0;
            p2_data  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                p1_valid[p] <= rd_acc[p];
                p2_valid[p] <= p1_valid[p];
                if (rd_acc[p])   p1_data[p] <= mem[addr[p]];
                if (p1_valid[p]) p2_data[p] <= p1_data[p];
            end
        end
    end

    assign rdata  = (READ_LATENCY == 2) ? p2_data  : p1_data;
    assign rvalid = (READ_LATENCY == 2) ? p2_valid : p1_valid;

    assign s1_readdata      = rdata[0];
    assign s2_readdata      = rdata[1];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdatavalid = rvalid[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_count <= '0;
        end else if (collide && collision_count != 16'hFFFF) begin
            collision_count <= collision_count + 16'd1;
        end
    end
endmodule
